// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode classes, sequencer states and counter widths
// for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    localparam logic [3:0] OP_LD  = 4'b1000;
    localparam logic [3:0] OP_ST  = 4'b1001;
    localparam logic [3:0] OP_RES = 4'b1010;
    localparam logic [3:0] OP_BEQ = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1111;

    localparam int STALL_W = 16;
    localparam int WAIT_W  = 8;

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        ERR
    } seq_state_t;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

endpackage

// File: rtl/pipeline_sequencer_hazard.sv
// Combinational ID/EX hazard detection: load-use and
// taken-branch/jump redirect.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = 3
) (
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_valid,
    input  logic [3:0]        ex_opcode,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_valid,
    input  logic              ex_branch_taken,
    output logic              load_use,
    output logic              redirect
);

    logic rd_match;

    // r0 is hardwired zero, so it never forwards a stale value
    assign rd_match = (ex_rd != '0)
                   && ((id_rs1 == ex_rd) || (id_rs2 == ex_rd));

    assign load_use = ex_valid && (ex_opcode == OP_LD)
                   && id_valid && rd_match;

    assign redirect = ex_valid
                   && ((ex_opcode == OP_JMP)
                    || ((ex_opcode == OP_BEQ) && ex_branch_taken));

endmodule

// File: rtl/pipeline_sequencer.sv
// Central stall/flush sequencer: load-use stalls, redirects and
// multi-cycle data-memory waits with timeout.
module pipeline_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW      = 3,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         id_opcode,
    input  logic [REG_AW-1:0]  id_rs1,
    input  logic [REG_AW-1:0]  id_rs2,
    input  logic               id_valid,
    input  logic [3:0]         ex_opcode,
    input  logic [REG_AW-1:0]  ex_rd,
    input  logic               ex_valid,
    input  logic               ex_branch_taken,
    input  logic [3:0]         mem_opcode,
    input  logic               mem_valid,
    input  logic               mem_ack,
    output logic               mem_req,
    output logic               pc_en,
    output logic               if_id_en,
    output logic               id_ex_en,
    output logic               ex_mem_en,
    output logic               mem_wb_en,
    output logic               if_id_flush,
    output logic               id_ex_flush,
    output logic               mem_err,
    output logic [STALL_W-1:0] stall_cnt
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    seq_state_t        state;
    seq_state_t        state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              load_use;
    logic              redirect;
    logic              normal;
    logic              id_unused;

    // ID opcode is observed but no current rule depends on it
    assign id_unused = ^id_opcode;

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard (
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_valid        (id_valid),
        .ex_opcode       (ex_opcode),
        .ex_rd           (ex_rd),
        .ex_valid        (ex_valid),
        .ex_branch_taken (ex_branch_taken),
        .load_use        (load_use),
        .redirect        (redirect)
    );

    always_comb begin
        state_next = state;
        normal     = 1'b0;
        unique case (state)
            RUN: begin
                if (mem_valid && is_mem_op(mem_opcode))
                    state_next = MEM_WAIT;
                else
                    normal = 1'b1;
            end
            MEM_WAIT: begin
                // an ack on the last allowed cycle still wins
                if (mem_ack) begin
                    normal     = 1'b1;
                    state_next = RUN;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next = ERR;
                end
            end
            ERR: state_next = ERR;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_en    = 1'b0;
        ex_mem_en   = 1'b0;
        mem_wb_en   = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (normal) begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
            if (redirect) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_req   <= 1'b0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state   <= state_next;
            mem_req <= (state_next == MEM_WAIT);
            mem_err <= (state_next == ERR);
            if (state != MEM_WAIT)
                wait_cnt <= '0;
            else if (!mem_ack)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            if (!pc_en && (stall_cnt != '1))
                stall_cnt <= stall_cnt + STALL_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer: per-cycle expected
// enables/flushes/req/err/stall_cnt queued at drive, checked at sample.
module tb_pipeline_sequencer;
    import pipe_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  id_opcode = '0;
    logic [2:0]  id_rs1 = '0, id_rs2 = '0;
    logic        id_valid = 1'b0;
    logic [3:0]  ex_opcode = '0;
    logic [2:0]  ex_rd = '0;
    logic        ex_valid = 1'b0, ex_branch_taken = 1'b0;
    logic [3:0]  mem_opcode = '0;
    logic        mem_valid = 1'b0, mem_ack = 1'b0;
    logic        mem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, mem_err;
    logic [15:0] stall_cnt;

    pipeline_sequencer #(.REG_AW(3), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_valid(id_valid), .ex_opcode(ex_opcode), .ex_rd(ex_rd),
        .ex_valid(ex_valid), .ex_branch_taken(ex_branch_taken),
        .mem_opcode(mem_opcode), .mem_valid(mem_valid), .mem_ack(mem_ack),
        .mem_req(mem_req), .pc_en(pc_en), .if_id_en(if_id_en),
        .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] exop;
        logic [2:0] rd;
        logic       exv;
        logic       bt;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic       idv;
        logic [3:0] memop;
        logic       memv;
        logic       ack;
    } stim_t;

    typedef struct packed {
        stim_t      s;
        logic [6:0] ef;
        logic       req;
        logic       err;
    } row_t;

    // enables {pc,if_id,id_ex,ex_mem,mem_wb} then flushes {if_id,id_ex}
    localparam logic [6:0] ALL1 = 7'b11111_00;
    localparam logic [6:0] FRZ  = 7'b00000_00;
    localparam logic [6:0] LU   = 7'b00111_01;
    localparam logic [6:0] RED  = 7'b11111_11;

    int          asserts = 0;
    int          fails = 0;
    logic [15:0] sc_model = '0;
    logic [24:0] sb[$];
    logic [24:0] got, want;

    function automatic stim_t mk(logic [3:0] exop, logic [2:0] rd,
                                 logic exv, logic bt, logic [2:0] rs1,
                                 logic [2:0] rs2, logic idv,
                                 logic [3:0] memop, logic memv, logic ack);
        stim_t s;
        s = '{exop, rd, exv, bt, rs1, rs2, idv, memop, memv, ack};
        return s;
    endfunction

    function automatic row_t rw(stim_t s, logic [6:0] ef,
                                logic req, logic err);
        row_t r;
        r = '{s, ef, req, err};
        return r;
    endfunction

    function automatic logic [24:0] observe();
        return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_flush, id_ex_flush, mem_req, mem_err, stall_cnt};
    endfunction

    task automatic apply(stim_t s);
        @(negedge clk);
        id_opcode = 4'h1;
        ex_opcode = s.exop; ex_rd = s.rd; ex_valid = s.exv;
        ex_branch_taken = s.bt; id_rs1 = s.rs1; id_rs2 = s.rs2;
        id_valid = s.idv; mem_opcode = s.memop; mem_valid = s.memv;
        mem_ack = s.ack;
    endtask

    // push expected for this cycle and advance the stall model
    task automatic expect_row(row_t r);
        sb.push_back({r.ef, r.req, r.err, sc_model});
        if (!r.ef[6] && sc_model != 16'hFFFF) sc_model = sc_model + 16'd1;
    endtask

    stim_t idle;

    task automatic test_reset();
        rst_n = 1'b0;
        apply(idle);
        sc_model = '0;
        expect_row(rw(idle, ALL1, 1'b0, 1'b0));
        #1;
        got = observe(); want = sb.pop_front(); asserts++;
        if (got !== want) begin
            fails++;
            $display("FAIL reset: got %h want %h", got, want);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        row_t t[$];
        t.push_back(rw(mk(OP_LD, 3, 1, 0, 1, 3, 1, 0, 0, 0), LU, 0, 0));
        t.push_back(rw(idle, ALL1, 0, 0));
        t.push_back(rw(mk(OP_LD, 0, 1, 0, 0, 0, 1, 0, 0, 0), ALL1, 0, 0));
        t.push_back(rw(mk(OP_LD, 5, 1, 0, 5, 2, 1, 0, 0, 0), LU, 0, 0));
        t.push_back(rw(mk(OP_LD, 5, 1, 0, 5, 2, 0, 0, 0, 0), ALL1, 0, 0));
        t.push_back(rw(mk(OP_ST, 3, 1, 0, 3, 3, 1, 0, 0, 0), ALL1, 0, 0));
        t.push_back(rw(mk(OP_LD, 3, 0, 0, 3, 3, 1, 0, 0, 0), ALL1, 0, 0));
        foreach (t[i]) begin
            apply(t[i].s);
            expect_row(t[i]);
            #1;
            got = observe(); want = sb.pop_front(); asserts++;
            if (got !== want) begin
                fails++;
                $display("FAIL load_use[%0d]: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_redirect();
        row_t t[$];
        t.push_back(rw(mk(OP_BEQ, 3, 1, 1, 3, 3, 1, 0, 0, 0), RED, 0, 0));
        t.push_back(rw(mk(OP_BEQ, 3, 1, 0, 3, 3, 1, 0, 0, 0), ALL1, 0, 0));
        t.push_back(rw(mk(OP_JMP, 2, 1, 0, 2, 1, 1, 0, 0, 0), RED, 0, 0));
        t.push_back(rw(mk(OP_JMP, 2, 0, 1, 2, 1, 1, 0, 0, 0), ALL1, 0, 0));
        t.push_back(rw(mk(OP_RES, 2, 1, 1, 2, 1, 1, 0, 0, 0), ALL1, 0, 0));
        foreach (t[i]) begin
            apply(t[i].s);
            expect_row(t[i]);
            #1;
            got = observe(); want = sb.pop_front(); asserts++;
            if (got !== want) begin
                fails++;
                $display("FAIL redirect[%0d]: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_mem_ack3();
        row_t t[$];
        stim_t st, st_ack;
        st = mk(0, 0, 0, 0, 0, 0, 0, OP_ST, 1, 0);
        st_ack = mk(0, 0, 0, 0, 0, 0, 0, OP_ST, 1, 1);
        t.push_back(rw(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), ALL1, 0, 0));
        t.push_back(rw(st_ack, FRZ, 0, 0));
        t.push_back(rw(st, FRZ, 1, 0));
        t.push_back(rw(st, FRZ, 1, 0));
        t.push_back(rw(st, FRZ, 1, 0));
        t.push_back(rw(st_ack, ALL1, 1, 0));
        t.push_back(rw(idle, ALL1, 0, 0));
        foreach (t[i]) begin
            apply(t[i].s);
            expect_row(t[i]);
            #1;
            got = observe(); want = sb.pop_front(); asserts++;
            if (got !== want) begin
                fails++;
                $display("FAIL mem_ack3[%0d]: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_release_hazard();
        row_t t[$];
        t.push_back(rw(mk(OP_LD, 4, 1, 0, 4, 0, 1, OP_LD, 1, 0), FRZ, 0, 0));
        t.push_back(rw(mk(OP_LD, 4, 1, 0, 4, 0, 1, OP_LD, 1, 1), LU, 1, 0));
        t.push_back(rw(mk(OP_JMP, 1, 1, 0, 0, 0, 0, OP_ST, 1, 0), FRZ, 0, 0));
        t.push_back(rw(mk(OP_JMP, 1, 1, 0, 0, 0, 0, OP_ST, 1, 1), RED, 1, 0));
        t.push_back(rw(idle, ALL1, 0, 0));
        foreach (t[i]) begin
            apply(t[i].s);
            expect_row(t[i]);
            #1;
            got = observe(); want = sb.pop_front(); asserts++;
            if (got !== want) begin
                fails++;
                $display("FAIL release[%0d]: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_ack_at_limit();
        row_t t[$];
        stim_t ld;
        ld = mk(0, 0, 0, 0, 0, 0, 0, OP_LD, 1, 0);
        t.push_back(rw(ld, FRZ, 0, 0));
        for (int k = 0; k < 3; k++) t.push_back(rw(ld, FRZ, 1, 0));
        t.push_back(rw(mk(0, 0, 0, 0, 0, 0, 0, OP_LD, 1, 1), ALL1, 1, 0));
        t.push_back(rw(idle, ALL1, 0, 0));
        foreach (t[i]) begin
            apply(t[i].s);
            expect_row(t[i]);
            #1;
            got = observe(); want = sb.pop_front(); asserts++;
            if (got !== want) begin
                fails++;
                $display("FAIL ack_limit[%0d]: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_timeout();
        row_t t[$];
        stim_t ld;
        ld = mk(0, 0, 0, 0, 0, 0, 0, OP_LD, 1, 0);
        t.push_back(rw(ld, FRZ, 0, 0));
        for (int k = 0; k < 4; k++) t.push_back(rw(ld, FRZ, 1, 0));
        t.push_back(rw(idle, FRZ, 0, 1));
        t.push_back(rw(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), FRZ, 0, 1));
        t.push_back(rw(mk(OP_JMP, 0, 1, 0, 0, 0, 0, 0, 0, 0), FRZ, 0, 1));
        t.push_back(rw(idle, FRZ, 0, 1));
        foreach (t[i]) begin
            apply(t[i].s);
            expect_row(t[i]);
            #1;
            got = observe(); want = sb.pop_front(); asserts++;
            if (got !== want) begin
                fails++;
                $display("FAIL timeout[%0d]: got %h want %h", i, got, want);
            end
        end
        test_reset();
        apply(idle);
        expect_row(rw(idle, ALL1, 0, 0));
        #1;
        got = observe(); want = sb.pop_front(); asserts++;
        if (got !== want) begin
            fails++;
            $display("FAIL timeout_recover: got %h want %h", got, want);
        end
    endtask

    task automatic test_mid_wait_reset();
        row_t t[$];
        stim_t st;
        st = mk(0, 0, 0, 0, 0, 0, 0, OP_ST, 1, 0);
        t.push_back(rw(st, FRZ, 0, 0));
        t.push_back(rw(st, FRZ, 1, 0));
        foreach (t[i]) begin
            apply(t[i].s);
            expect_row(t[i]);
            #1;
            got = observe(); want = sb.pop_front(); asserts++;
            if (got !== want) begin
                fails++;
                $display("FAIL mid_reset[%0d]: got %h want %h", i, got, want);
            end
        end
        #1;
        mem_valid = 1'b0;
        rst_n = 1'b0;
        sc_model = '0;
        sb.push_back({ALL1, 1'b0, 1'b0, sc_model});
        #1;
        got = observe(); want = sb.pop_front(); asserts++;
        if (got !== want) begin
            fails++;
            $display("FAIL mid_reset_async: got %h want %h", got, want);
        end
        @(negedge clk);
        rst_n = 1'b1;
        apply(idle);
        expect_row(rw(idle, ALL1, 0, 0));
        #1;
        got = observe(); want = sb.pop_front(); asserts++;
        if (got !== want) begin
            fails++;
            $display("FAIL mid_reset_after: got %h want %h", got, want);
        end
    endtask

    initial begin
        idle = '0;
        test_reset();
        test_load_use();
        test_redirect();
        test_mem_ack3();
        test_release_hazard();
        test_ack_at_limit();
        test_timeout();
        test_mid_wait_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 asserts, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
